life_engine_seq: RTL
====================

Name: life_engine_seq

Overview:
- Sequential, parametrised Conway's Game of Life engine for a WIDTH x HEIGHT grid with rule B3/S23.
- Holds the current generation in a register array. Computes the next generation one row per cycle into a shadow buffer, then commits it in a single cycle.
- Supports toroidal or dead-boundary edges, single-step or free-running operation, row-wise load and readout, a generation counter and a still-life detector.
- Sits between the host/pattern loader and the display scanner.

Parameters:
- WIDTH, 16, columns per row (>=3).
- HEIGHT, 16, number of rows (>=3).
- ROW_AW, 4, row index width; must satisfy 2^ROW_AW >= HEIGHT.
- GEN_W, 16, generation counter width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear of grid and counter; honoured in IDLE only.
- load_en  in  1  write load_data into row load_idx; honoured in IDLE only.
- load_idx  in  ROW_AW  row to write.
- load_data  in  WIDTH  row contents; bit c = column c, 1 = alive.
- wrap_mode  in  1  1 = torus, 0 = cells outside the grid are dead; sampled at step accept.
- step_req  in  1  request one generation.
- run  in  1  free-run; behaves as step_req held high.
- rd_idx  in  ROW_AW  readout row select.
- rd_data  out  WIDTH  combinational row rd_idx of the current grid; 0 if rd_idx >= HEIGHT.
- busy  out  1  high in COMPUTE and COMMIT.
- gen_done  out  1  one-cycle pulse when a new generation is committed.
- generation  out  GEN_W  committed generations since reset or clear.
- stable  out  1  last committed generation equals its predecessor.

Behaviour:
- Reset (async): grid all 0, shadow all 0, FSM=IDLE, row counter 0, busy=0, gen_done=0, generation=0, stable=0.
- FSM states: IDLE, COMPUTE, COMMIT.
- IDLE priority, highest first: clear, then load_en, then (step_req|run). Only one of these acts per cycle.
  - clear: grid=0, generation=0, stable=0.
  - load_en: grid[load_idx]=load_data; stable is cleared. If load_idx >= HEIGHT, no write occurs.
  - step_req or run: latch wrap_mode, row=0, go to COMPUTE.
- COMPUTE (HEIGHT cycles):
  - Each cycle, compute shadow[row] from grid rows row-1, row, row+1. Row and column wrap or are forced dead per the latched mode.
  - Neighbour count 0..8 per cell, 4 bits.
  - Rule: alive' = (n==3) | (alive & n==2). All other cases give 0.
  - row increments each cycle; after row==HEIGHT-1, go to COMMIT.
  - The grid is not modified during COMPUTE, so every row uses the old generation.
- COMMIT (1 cycle):
  - grid <= shadow.
  - stable <= (shadow == grid).
  - generation <= generation+1, wrapping from 2^GEN_W-1 to 0.
  - gen_done <= 1 for exactly the next cycle.
  - Go to IDLE.
- Latency: step accepted at edge T; new grid and gen_done are visible after edge T+HEIGHT+1. A full generation takes HEIGHT+1 cycles in COMPUTE plus COMMIT.
- With run held high, IDLE lasts one cycle between generations, giving a period of HEIGHT+2 cycles.
- step_req, clear and load_en asserted while busy are ignored; there is no queuing. A wrap_mode change while busy has no effect until the next accept.
- rd_data remains valid, showing the old generation, throughout COMPUTE.
- rst asserted mid-COMPUTE or mid-COMMIT returns to full reset state immediately. The partial shadow is discarded and nothing is committed.
- Dead-boundary mode: row -1, row HEIGHT, column -1 and column WIDTH read as 0.
- Torus mode: index -1 maps to the last index, and the last index + 1 maps to 0, on both axes.

Test Plan:
- Blinker: load rows 7,8,9 with bit 8 set, torus, one step → row 8 = 0x0380, rows 7/9 = 0; gen_done HEIGHT+1 cycles after accept; generation=1; stable=0. Second step restores the vertical pattern; generation=2.
- Block still life: 2x2 at rows 4–5, cols 4–5, step → grid unchanged, stable=1, generation=1.
- Glider edge behaviour with wrap_mode=1: glider at the bottom-right corner, 4 steps → reappears at the top-left shifted (+1,+1) with wrap.
- Same glider with wrap_mode=0: glider decays into a 2x2 block at the corner.
- Busy rules: during COMPUTE, pulse load_en to row 0 = 0xFFFF and pulse step_req → grid row 0 unchanged, exactly one gen_done; rd_data shows the old generation until commit.
- Reset mid-COMPUTE: rst at row 5 → busy=0, generation=0, grid=0, no gen_done. Free-run with GEN_W=2: run held high for 5 generations → generation sequence 1,2,3,0,1; gen_done period = HEIGHT+2 cycles.

Source files
------------

// File: rtl/life_engine_seq_if.sv
// Host-side bundle for the Life engine: control, load and readout in, grid row and status out.
interface life_engine_seq_if #(
  parameter int WIDTH  = 16,
  parameter int ROW_AW = 4,
  parameter int GEN_W  = 16
);
  logic              clear;
  logic              load_en;
  logic [ROW_AW-1:0] load_idx;
  logic [WIDTH-1:0]  load_data;
  logic              wrap_mode;
  logic              step_req;
  logic              run;
  logic [ROW_AW-1:0] rd_idx;
  logic [WIDTH-1:0]  rd_data;
  logic              busy;
  logic              gen_done;
  logic [GEN_W-1:0]  generation;
  logic              stable;

  modport master (
    output clear, load_en, load_idx, load_data, wrap_mode, step_req, run, rd_idx,
    input  rd_data, busy, gen_done, generation, stable
  );

  modport slave (
    input  clear, load_en, load_idx, load_data, wrap_mode, step_req, run, rd_idx,
    output rd_data, busy, gen_done, generation, stable
  );
endinterface

// File: rtl/life_engine_seq.sv
// B3/S23 Life engine: one shadow row per cycle, then a one-cycle commit (HEIGHT+1 cycles after accept).
// Requests arriving while busy are dropped, not queued; readout keeps showing the old generation.
module life_engine_seq #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16,
  parameter int ROW_AW = 4,
  parameter int GEN_W  = 16
) (
  input logic              clk,
  input logic              rst,
  life_engine_seq_if.slave bus
);
  localparam int ROWS = 2 ** ROW_AW;
  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT} state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  grid_q   [ROWS];
  logic [WIDTH-1:0]  shadow_q [ROWS];
  logic [ROW_AW-1:0] row_q;
  logic              wrap_q;
  logic              busy_q;
  logic              gen_done_q;
  logic              stable_q;
  logic [GEN_W-1:0]  gen_q;

  logic [WIDTH-1:0]  up_row, mid_row, dn_row, row_d;
  logic [WIDTH+1:0]  up_x, mid_x, dn_x;
  logic [3:0]        n;
  logic              same;

  // Bit 0 is column -1 and bit WIDTH+1 is column WIDTH; both dead unless wrapping.
  function automatic logic [WIDTH+1:0] extend(input logic [WIDTH-1:0] r, input logic wrap);
    return {wrap & r[0], r, wrap & r[WIDTH-1]};
  endfunction

  always_comb begin
    mid_row = grid_q[row_q];
    if (row_q == '0) up_row = wrap_q ? grid_q[LAST_ROW] : '0;
    else             up_row = grid_q[row_q - 1'b1];
    if (row_q == LAST_ROW) dn_row = wrap_q ? grid_q[0] : '0;
    else                   dn_row = grid_q[row_q + 1'b1];
    up_x  = extend(up_row, wrap_q);
    mid_x = extend(mid_row, wrap_q);
    dn_x  = extend(dn_row, wrap_q);
    n     = '0;
    row_d = '0;
    for (int c = 0; c < WIDTH; c++) begin
      n = 4'(up_x[c]) + 4'(up_x[c+1]) + 4'(up_x[c+2]) +
          4'(mid_x[c]) + 4'(mid_x[c+2]) +
          4'(dn_x[c]) + 4'(dn_x[c+1]) + 4'(dn_x[c+2]);
      row_d[c] = (n == 4'd3) | (mid_row[c] & (n == 4'd2));
    end
  end

  always_comb begin
    same = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      if (shadow_q[r] != grid_q[r]) same = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      for (int r = 0; r < ROWS; r++) begin
        grid_q[r]   <= '0;
        shadow_q[r] <= '0;
      end
      row_q      <= '0;
      wrap_q     <= 1'b0;
      busy_q     <= 1'b0;
      gen_done_q <= 1'b0;
      stable_q   <= 1'b0;
      gen_q      <= '0;
    end else begin
      gen_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.clear) begin
            for (int r = 0; r < ROWS; r++) grid_q[r] <= '0;
            gen_q    <= '0;
            stable_q <= 1'b0;
          end else if (bus.load_en) begin
            if (int'(bus.load_idx) < HEIGHT) grid_q[bus.load_idx] <= bus.load_data;
            stable_q <= 1'b0;
          end else if (bus.step_req | bus.run) begin
            wrap_q  <= bus.wrap_mode;
            row_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= COMPUTE;
          end
        end
        COMPUTE: begin
          shadow_q[row_q] <= row_d;
          if (row_q == LAST_ROW) state_q <= COMMIT;
          else                   row_q   <= row_q + 1'b1;
        end
        COMMIT: begin
          for (int r = 0; r < ROWS; r++) grid_q[r] <= shadow_q[r];
          stable_q   <= same;
          gen_q      <= gen_q + 1'b1;
          gen_done_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rd_data    = (int'(bus.rd_idx) < HEIGHT) ? grid_q[bus.rd_idx] : '0;
  assign bus.busy       = busy_q;
  assign bus.gen_done   = gen_done_q;
  assign bus.generation = gen_q;
  assign bus.stable     = stable_q;
endmodule
